// File: rtl/cpu_pkg.sv
// Constants and types shared by the instruction-side blocks of the single-cycle CPU:
// the PC register, the instruction memory, the datapath and the program loader.
package cpu_pkg;

  localparam int ADDR_W         = 12;
  localparam int INSTR_W        = 19;
  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 3;

  typedef enum logic [3:0] {
    IDLE,
    HDR_LO,
    HDR_HI,
    B0,
    B1,
    B2,
    WRITE,
    DONE,
    ERROR
  } loader_state_t;

  // States in which the loader is waiting for a stream byte.
  function automatic logic takes_byte(loader_state_t s);
    return (s == HDR_LO) || (s == HDR_HI) || (s == B0) || (s == B1) || (s == B2);
  endfunction

  // States in which a new load may begin.
  function automatic logic is_rest(loader_state_t s);
    return (s == IDLE) || (s == DONE) || (s == ERROR);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Program loader: unpacks a header plus 3-byte-per-word byte stream into
// 19-bit instruction words and drives the instruction memory write port.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int                 ADDR_W    = cpu_pkg::ADDR_W,
  parameter int                 INSTR_W   = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               err
);

  loader_state_t     state, state_next;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] idx;
  logic [15:0]       word_lo;
  logic              xfer;

  assign xfer     = in_valid && in_ready;
  assign cpu_hold = busy;

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERROR: if (start) state_next = HDR_LO;
      HDR_LO:            if (xfer) state_next = HDR_HI;
      HDR_HI:            if (xfer) state_next = (in_data[7:4] != 4'd0) ? ERROR : B0;
      B0:                if (xfer) state_next = B1;
      B1:                if (xfer) state_next = B2;
      B2:                if (xfer) state_next = (in_data[7:3] != 5'd0) ? ERROR : WRITE;
      WRITE:             state_next = (idx == cnt) ? DONE : B0;
      default:           state_next = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they are registered yet
  // line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      cnt      <= '0;
      idx      <= '0;
      word_lo  <= '0;
    end else begin
      state    <= state_next;
      in_ready <= takes_byte(state_next);
      busy     <= !is_rest(state_next);
      done     <= (state_next == DONE);
      err      <= (state_next == ERROR);
      wr_en    <= (state_next == WRITE);
      case (state)
        IDLE, DONE, ERROR: if (start) idx <= '0;
        HDR_LO:            if (xfer) cnt[7:0] <= in_data;
        HDR_HI:            if (xfer) cnt[ADDR_W-1:8] <= in_data[ADDR_W-9:0];
        B0:                if (xfer) word_lo[7:0] <= in_data;
        B1:                if (xfer) word_lo[15:8] <= in_data;
        B2: begin
          if (xfer && (in_data[7:3] == 5'd0)) begin
            wr_addr <= BASE_ADDR + idx;
            wr_data <= {in_data[2:0], word_lo};
          end
        end
        WRITE:             if (idx != cnt) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
